// File: rtl/axi_lite_drv_master.sv
// Single-outstanding AXI4-Lite master: turns one valid/ready request into an
// AXI-Lite read or write and returns the response code with an error flag.
module axi_lite_drv_master #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_write_i,
  input  logic [AW-1:0]   req_addr_i,
  input  logic [DW-1:0]   req_wdata_i,
  input  logic [DW/8-1:0] req_wstrb_i,
  output logic            rsp_valid_o,
  output logic [DW-1:0]   rsp_rdata_o,
  output logic [1:0]      rsp_resp_o,
  output logic            rsp_err_o,
  output logic [7:0]      err_cnt_o,
  output logic [AW-1:0]   aw_addr_o,
  output logic [2:0]      aw_prot_o,
  output logic            aw_valid_o,
  input  logic            aw_ready_i,
  output logic [DW-1:0]   w_data_o,
  output logic [DW/8-1:0] w_strb_o,
  output logic            w_valid_o,
  input  logic            w_ready_i,
  input  logic [1:0]      b_resp_i,
  input  logic            b_valid_i,
  output logic            b_ready_o,
  output logic [AW-1:0]   ar_addr_o,
  output logic [2:0]      ar_prot_o,
  output logic            ar_valid_o,
  input  logic            ar_ready_i,
  input  logic [DW-1:0]   r_data_i,
  input  logic [1:0]      r_resp_i,
  input  logic            r_valid_i,
  output logic            r_ready_o
);

  localparam int unsigned SW = DW / 8;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA
  } state_t;

  state_t          state_q, state_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            aw_done_now, w_done_now;
  logic            req_ready_d, aw_valid_d, w_valid_d, b_ready_d;
  logic            ar_valid_d, r_ready_d, rsp_valid_d, rsp_err_d;
  logic [AW-1:0]   aw_addr_d, ar_addr_d;
  logic [DW-1:0]   w_data_d, rsp_rdata_d;
  logic [SW-1:0]   w_strb_d;
  logic [1:0]      rsp_resp_d;
  logic [7:0]      err_cnt_d;
  logic            cap_valid;
  logic [1:0]      cap_resp;

  assign aw_prot_o = 3'b000;
  assign ar_prot_o = 3'b000;

  // A channel counts as done once its handshake has happened, including this cycle
  assign aw_done_now = aw_done_q | (aw_valid_o & aw_ready_i);
  assign w_done_now  = w_done_q  | (w_valid_o  & w_ready_i);

  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    req_ready_d = 1'b0;
    aw_valid_d  = 1'b0;
    w_valid_d   = 1'b0;
    b_ready_d   = 1'b0;
    ar_valid_d  = 1'b0;
    r_ready_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_o;
    rsp_resp_d  = rsp_resp_o;
    rsp_err_d   = rsp_err_o;
    err_cnt_d   = err_cnt_o;
    aw_addr_d   = aw_addr_o;
    w_data_d    = w_data_o;
    w_strb_d    = w_strb_o;
    ar_addr_d   = ar_addr_o;
    cap_valid   = 1'b0;
    cap_resp    = 2'b00;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_write_i) begin
            state_d    = WR_ADDR_DATA;
            aw_addr_d  = req_addr_i;
            w_data_d   = req_wdata_i;
            w_strb_d   = req_wstrb_i;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
          end else begin
            state_d    = RD_ADDR;
            ar_addr_d  = req_addr_i;
            ar_valid_d = 1'b1;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      WR_ADDR_DATA: begin
        aw_done_d = aw_done_now;
        w_done_d  = w_done_now;
        if (aw_done_now && w_done_now) begin
          state_d   = WR_RESP;
          b_ready_d = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else begin
          aw_valid_d = ~aw_done_now;
          w_valid_d  = ~w_done_now;
        end
      end
      WR_RESP: begin
        if (b_valid_i) begin
          cap_valid   = 1'b1;
          cap_resp    = b_resp_i;
          rsp_rdata_d = '0;
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          b_ready_d = 1'b1;
        end
      end
      RD_ADDR: begin
        if (ar_ready_i) begin
          state_d   = RD_DATA;
          r_ready_d = 1'b1;
        end else begin
          ar_valid_d = 1'b1;
        end
      end
      RD_DATA: begin
        if (r_valid_i) begin
          cap_valid   = 1'b1;
          cap_resp    = r_resp_i;
          rsp_rdata_d = r_data_i;
          state_d     = IDLE;
          req_ready_d = 1'b1;
        end else begin
          r_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase

    // Response pulse lands in the first IDLE cycle; any non-OKAY code is an error
    if (cap_valid) begin
      rsp_valid_d = 1'b1;
      rsp_resp_d  = cap_resp;
      rsp_err_d   = (cap_resp != 2'b00);
      if ((cap_resp != 2'b00) && (err_cnt_o != 8'hFF)) begin
        err_cnt_d = err_cnt_o + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      req_ready_o <= 1'b1;
      aw_valid_o  <= 1'b0;
      w_valid_o   <= 1'b0;
      b_ready_o   <= 1'b0;
      ar_valid_o  <= 1'b0;
      r_ready_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_resp_o  <= 2'b00;
      rsp_err_o   <= 1'b0;
      err_cnt_o   <= 8'd0;
      aw_addr_o   <= '0;
      w_data_o    <= '0;
      w_strb_o    <= '0;
      ar_addr_o   <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      req_ready_o <= req_ready_d;
      aw_valid_o  <= aw_valid_d;
      w_valid_o   <= w_valid_d;
      b_ready_o   <= b_ready_d;
      ar_valid_o  <= ar_valid_d;
      r_ready_o   <= r_ready_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_rdata_o <= rsp_rdata_d;
      rsp_resp_o  <= rsp_resp_d;
      rsp_err_o   <= rsp_err_d;
      err_cnt_o   <= err_cnt_d;
      aw_addr_o   <= aw_addr_d;
      w_data_o    <= w_data_d;
      w_strb_o    <= w_strb_d;
      ar_addr_o   <= ar_addr_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_drv_master.sv
// Bench for axi_lite_drv_master: table vectors plus random traffic against a
// transaction-level response model and a delay-programmable AXI-Lite slave.
module tb_axi_lite_drv_master;

  logic        clk_i, rst_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic [7:0]  err_cnt_o;
  logic [31:0] aw_addr_o, w_data_o, ar_addr_o, r_data_i;
  logic [2:0]  aw_prot_o, ar_prot_o;
  logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i;
  logic [3:0]  w_strb_o;
  logic [1:0]  b_resp_i, r_resp_i;
  logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i, r_valid_i, r_ready_o;

  axi_lite_drv_master #(.AW(32), .DW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o),
    .rsp_err_o(rsp_err_o), .err_cnt_o(err_cnt_o),
    .aw_addr_o(aw_addr_o), .aw_prot_o(aw_prot_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
    .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
    .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
    .ar_addr_o(ar_addr_o), .ar_prot_o(ar_prot_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
    .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
  );

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  int   nvec, nfail, cyc;
  int   stray_req;
  exp_t exp_q[$];
  vec_t slv_q[$];
  int   rsp_cyc_q[$];
  vec_t tbl[7];

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, input int awd, input int wd, input int bd,
                              input int ard, input int rd, input logic [1:0] resp, input logic [31:0] rdata,
                              input logic [31:0] erd, input logic [1:0] ersp, input logic eerr, input int elat);
    vec_t v;
    v.write = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
    v.resp = resp; v.rdata = rdata;
    v.exp_rdata = erd; v.exp_resp = ersp; v.exp_err = eerr; v.exp_lat = elat;
    return v;
  endfunction

  // Transaction-level expectation: slave's code passes through, reads return slave data
  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.rdata = v.write ? 32'h0 : v.rdata;
    e.resp  = v.resp;
    e.err   = (v.resp != 2'b00);
    e.lat   = v.write ? 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly
                      : 3 + v.ar_dly + v.r_dly;
    e.acc   = 0;
    return e;
  endfunction

  function automatic exp_t from_table(input vec_t v);
    exp_t e;
    e.rdata = v.exp_rdata; e.resp = v.exp_resp; e.err = v.exp_err; e.lat = v.exp_lat; e.acc = 0;
    return e;
  endfunction

  task automatic issue(input vec_t v, input exp_t e, output int acc);
    int n;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_write_i = v.write;
    req_addr_i  = v.addr;
    req_wdata_i = v.wdata;
    req_wstrb_i = v.strb;
    n = 0;
    while (!req_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    if (!req_ready_o) begin
      nvec++; nfail++;
      $display("FAIL req_accept_timeout: req_ready_o stayed 0 for %0d cycles", n);
      acc = -1;
      return;
    end
    acc = cyc;
    e.acc = cyc;
    exp_q.push_back(e);
    slv_q.push_back(v);
    @(posedge clk_i);
  endtask

  task automatic drop_req();
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    if (exp_q.size() > 0) begin
      nvec++; nfail++;
      $display("FAIL rsp_timeout: %0d responses still outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, 64'(req_ready_o), 64'h1);
    check({tag, ".aw_valid"},  64'(aw_valid_o),  64'h0);
    check({tag, ".w_valid"},   64'(w_valid_o),   64'h0);
    check({tag, ".b_ready"},   64'(b_ready_o),   64'h0);
    check({tag, ".ar_valid"},  64'(ar_valid_o),  64'h0);
    check({tag, ".r_ready"},   64'(r_ready_o),   64'h0);
    check({tag, ".rsp_valid"}, 64'(rsp_valid_o), 64'h0);
    check({tag, ".rsp_rdata"}, 64'(rsp_rdata_o), 64'h0);
    check({tag, ".rsp_resp"},  64'(rsp_resp_o),  64'h0);
    check({tag, ".rsp_err"},   64'(rsp_err_o),   64'h0);
    check({tag, ".err_cnt"},   64'(err_cnt_o),   64'h0);
    check({tag, ".aw_addr"},   64'(aw_addr_o),   64'h0);
    check({tag, ".w_data"},    64'(w_data_o),    64'h0);
    check({tag, ".w_strb"},    64'(w_strb_o),    64'h0);
    check({tag, ".ar_addr"},   64'(ar_addr_o),   64'h0);
    check({tag, ".prot"},      64'({aw_prot_o, ar_prot_o}), 64'h0);
  endtask

  // Slave: per-transaction ready delays and responses, all driven on the falling edge
  initial begin
    vec_t cur;
    bit   have_cur, aw_h, w_h, ar_h, b_pend, r_pend;
    int   awc, wc, arc, bc, rc, stray_seen;
    have_cur = 0; aw_h = 0; w_h = 0; ar_h = 0; b_pend = 0; r_pend = 0;
    awc = 0; wc = 0; arc = 0; bc = 0; rc = 0; stray_seen = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        have_cur = 0; b_pend = 0; r_pend = 0;
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; r_valid_i = 0;
        slv_q.delete();
        continue;
      end
      if (!have_cur && slv_q.size() > 0 && (aw_valid_o || w_valid_o || ar_valid_o)) begin
        cur = slv_q.pop_front();
        have_cur = 1; aw_h = 0; w_h = 0; ar_h = 0; b_pend = 0; r_pend = 0;
        awc = 0; wc = 0; arc = 0; bc = 0; rc = 0;
      end
      if (have_cur && cur.write) begin
        if (aw_ready_i) begin aw_ready_i = 0; aw_h = 1; end
        else if (aw_valid_o && !aw_h) begin
          check("aw_addr_stable", 64'(aw_addr_o), 64'(cur.addr));
          if (awc >= cur.aw_dly) aw_ready_i = 1; else awc++;
        end
        if (w_ready_i) begin w_ready_i = 0; w_h = 1; end
        else if (w_valid_o && !w_h) begin
          check("w_data_stable", 64'({w_strb_o, w_data_o}), 64'({cur.strb, cur.wdata}));
          if (wc >= cur.w_dly) w_ready_i = 1; else wc++;
        end
        if (aw_h) check("aw_valid_dropped", 64'(aw_valid_o), 64'h0);
        if (w_h)  check("w_valid_dropped",  64'(w_valid_o),  64'h0);
        if (b_valid_i) begin
          if (b_pend) begin b_valid_i = 0; b_pend = 0; have_cur = 0; end
          else if (b_ready_o) b_pend = 1;
        end else if (aw_h && w_h) begin
          if (bc >= cur.b_dly) begin
            b_valid_i = 1; b_resp_i = cur.resp;
            if (b_ready_o) b_pend = 1;
          end else bc++;
        end
      end else if (have_cur) begin
        if (ar_ready_i) begin ar_ready_i = 0; ar_h = 1; end
        else if (ar_valid_o && !ar_h) begin
          check("ar_addr_stable", 64'(ar_addr_o), 64'(cur.addr));
          if (arc >= cur.ar_dly) ar_ready_i = 1; else arc++;
        end
        if (ar_h) check("ar_valid_dropped", 64'(ar_valid_o), 64'h0);
        if (r_valid_i) begin
          if (r_pend) begin r_valid_i = 0; r_pend = 0; have_cur = 0; end
          else if (r_ready_o) r_pend = 1;
        end else if (ar_h) begin
          if (rc >= cur.r_dly) begin
            r_valid_i = 1; r_data_i = cur.rdata; r_resp_i = cur.resp;
            if (r_ready_o) r_pend = 1;
          end else rc++;
        end
      end
      if (!have_cur) begin
        if (stray_seen < stray_req) begin
          b_valid_i = 1; r_valid_i = 1; b_resp_i = 2'b10; r_resp_i = 2'b10; r_data_i = 32'hBAD0BAD0;
          stray_seen++;
        end else begin
          b_valid_i = 0; r_valid_i = 0;
        end
      end
    end
  end

  // Response monitor: pops the expectation queue on each rsp pulse
  initial begin
    exp_t e;
    int   mcnt;
    bit   prev;
    mcnt = 0; prev = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        exp_q.delete(); mcnt = 0; prev = 0;
        continue;
      end
      if (rsp_valid_o) begin
        check("rsp_single_cycle", 64'(prev), 64'h0);
        if (exp_q.size() == 0) begin
          nvec++; nfail++;
          $display("FAIL rsp_unexpected: rsp_valid_o=1 with nothing outstanding, resp=%0d", rsp_resp_o);
        end else begin
          e = exp_q.pop_front();
          if (e.err && mcnt < 255) mcnt++;
          check("rsp_rdata", 64'(rsp_rdata_o), 64'(e.rdata));
          check("rsp_resp",  64'(rsp_resp_o),  64'(e.resp));
          check("rsp_err",   64'(rsp_err_o),   64'(e.err));
          check("err_cnt",   64'(err_cnt_o),   64'(mcnt));
          if (e.lat >= 0) check("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          rsp_cyc_q.push_back(cyc);
        end
      end
      prev = rsp_valid_o;
    end
  end

  initial begin
    vec_t v, va, vb;
    exp_t e;
    int   acc, acc_a, acc_b, n;
    nvec = 0; nfail = 0; stray_req = 0;
    rst_i = 1'b1;
    req_valid_i = 0; req_write_i = 0; req_addr_i = 0; req_wdata_i = 0; req_wstrb_i = 0;
    aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0; b_valid_i = 0; b_resp_i = 0;
    r_valid_i = 0; r_resp_i = 0; r_data_i = 0;

    tbl[0] = mk(1, 32'h10,   32'h1000, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        2'b00, 0, 3);
    tbl[1] = mk(1, 32'h10,   32'h2000, 4'hF, 3, 0, 0, 0, 0, 2'b00, 32'h0,        32'h0,        2'b00, 0, 6);
    tbl[2] = mk(0, 32'h8004, 32'h0,    4'h0, 0, 0, 0, 0, 0, 2'b00, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0, 3);
    tbl[3] = mk(0, 32'h20,   32'h0,    4'h0, 0, 0, 0, 2, 1, 2'b10, 32'hCAFEF00D, 32'hCAFEF00D, 2'b10, 1, 6);
    tbl[4] = mk(1, 32'h44,   32'hA5A5, 4'h5, 0, 2, 2, 0, 0, 2'b11, 32'h0,        32'h0,        2'b11, 1, 7);
    tbl[5] = mk(1, 32'h48,   32'h1,    4'h1, 1, 1, 0, 0, 0, 2'b01, 32'h0,        32'h0,        2'b01, 1, 4);
    tbl[6] = mk(0, 32'h0,    32'h0,    4'h0, 0, 0, 0, 0, 3, 2'b01, 32'h12345678, 32'h12345678, 2'b01, 1, 6);

    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset");
    rst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      issue(tbl[i], from_table(tbl[i]), acc);
      drop_req();
      wait_idle();
    end

    for (int i = 0; i < 80; i++) begin
      v.write = 1'($urandom_range(0, 1));
      v.addr = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      v.wdata = $urandom; v.strb = 4'($urandom_range(0, 15));
      v.aw_dly = $urandom_range(0, 3); v.w_dly = $urandom_range(0, 3); v.b_dly = $urandom_range(0, 3);
      v.ar_dly = $urandom_range(0, 3); v.r_dly = $urandom_range(0, 3);
      v.resp = 2'($urandom_range(0, 3)); v.rdata = $urandom;
      issue(v, model(v), acc);
      if ($urandom_range(0, 1) == 0) drop_req();
    end
    drop_req();
    wait_idle();

    stray_req = 3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      check("stray_no_rsp", 64'({rsp_valid_o, req_ready_o, b_ready_o, r_ready_o}), 64'b0100);
    end

    for (int i = 0; i < 300; i++) begin
      v = mk(1, 32'h100 + 32'(i * 4), 32'(i), 4'hF, 0, 0, 0, 0, 0, 2'b10, 32'h0, 32'h0, 2'b10, 1, 3);
      issue(v, from_table(v), acc);
    end
    drop_req();
    wait_idle();
    @(negedge clk_i);
    check("err_cnt_saturated", 64'(err_cnt_o), 64'd255);

    v = mk(1, 32'h200, 32'h55, 4'hF, 0, 0, 8, 0, 0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 11);
    issue(v, model(v), acc);
    drop_req();
    n = 0;
    while (!b_ready_o && n < 50) begin @(negedge clk_i); n++; end
    check("reach_wr_resp", 64'(b_ready_o), 64'h1);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (2) begin
      @(negedge clk_i);
      check("abort_no_rsp", 64'(rsp_valid_o), 64'h0);
    end
    rst_i = 1'b0;
    issue(tbl[0], from_table(tbl[0]), acc);
    drop_req();
    wait_idle();

    rsp_cyc_q.delete();
    va = mk(1, 32'h300, 32'hFACE, 4'h3, 0, 0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b00, 0, 3);
    vb = mk(0, 32'h304, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h0BADF00D, 32'h0BADF00D, 2'b00, 0, 3);
    issue(va, from_table(va), acc_a);
    issue(vb, from_table(vb), acc_b);
    drop_req();
    wait_idle();
    check("b2b_rsp_count", 64'(rsp_cyc_q.size()), 64'd2);
    if (rsp_cyc_q.size() > 0) check("b2b_no_bubble", 64'(acc_b), 64'(rsp_cyc_q[0]));

    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/axi_lite_drv_master.md
# axi_lite_drv_master

Synthesizable AXI4-Lite single-outstanding master used to program the RAB configuration port (slice registers, L2 TLB set entries, invalidation range registers) from on-chip control logic. It accepts one read or write request at a time on a simple valid/ready request port and runs the matching AXI-Lite transaction. It returns the response code plus a pass/fail flag, matching the `write_ok` semantics where any non-OKAY response is an error. It sits between a configuration sequencer and the RAB AXI-Lite slave.

## Interface
- AW, 32, address width
- DW, 32, data width (strobe width DW/8)
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  AW  byte address
- req_wdata_i  in  DW  write data
- req_wstrb_i  in  DW/8  write strobes
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  DW  read data (0 for writes)
- rsp_resp_o  out  2  AXI response code
- rsp_err_o  out  1  rsp_resp_o != 2'b00
- err_cnt_o  out  8  saturating count of error responses
- aw_addr_o/aw_valid_o/aw_ready_i  AW/1/1  write address channel, aw_prot fixed 3'b000
- w_data_o/w_strb_o/w_valid_o/w_ready_i  DW/DW/8/1/1  write data channel
- b_resp_i/b_valid_i/b_ready_o  2/1/1  write response channel
- ar_addr_o/ar_valid_o/ar_ready_i  AW/1/1  read address channel, ar_prot 3'b000
- r_data_i/r_resp_i/r_valid_i/r_ready_o  DW/2/1/1  read data channel

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA.
- IDLE: req_ready_o=1. On handshake, register addr/data/strb; write → WR_ADDR_DATA, read → RD_ADDR.
- WR_ADDR_DATA: aw_valid_o and w_valid_o both rise together. Each drops independently after its own handshake, tracked by aw_done/w_done flags. Stays until both done, including the same-cycle case, then → WR_RESP.
- WR_RESP: b_ready_o=1. On b_valid_i, capture b_resp_i → IDLE with rsp_valid_o pulse.
- RD_ADDR: ar_valid_o=1 until ar_ready_i → RD_DATA.
- RD_DATA: r_ready_o=1. On r_valid_i, capture r_data_i/r_resp_i → IDLE with rsp_valid_o pulse.
- rsp_err_o = (captured resp != OKAY). err_cnt_o increments on each error pulse and saturates at 255.
- Payload outputs stay stable while the corresponding valid is high, as AXI requires. Valid is never withdrawn before its handshake.
- B or R arriving while not in WR_RESP/RD_DATA is ignored, since ready is low.

## Timing
- Reset: state=IDLE; all valid/ready outputs 0 except req_ready_o=1; rsp_* outputs 0, err_cnt_o=0, aw/w/ar payload outputs 0.
- Reset asserted mid-transaction aborts immediately. Outputs return to reset values asynchronously with no response pulse.
- Write latency with always-ready slave and B one cycle after AW/W: request at cycle 0, AW/W handshake at cycle 1, B handshake at cycle 2, rsp_valid_o at cycle 3.
- Read latency, same conditions: rsp_valid_o at cycle 3.
- rsp_valid_o is registered and high exactly one cycle, in the first IDLE cycle. req_ready_o is also 1 in that cycle, so back-to-back requests are allowed with no bubble.
- Only one transaction is ever outstanding. AXI IDs are not used.

## Test plan
- Write addr 0x10, data 0x1000, strb 0xF, slave always ready, B=OKAY → AW/W at cycle 1, rsp_valid at cycle 3, resp 00, err 0.
- Write with aw_ready delayed 3 cycles and w_ready immediate → w_valid drops after cycle 1, aw_valid held with stable 0x10 until handshake, single B handshake, one rsp pulse.
- Read addr 0x8004, R data 0xDEADBEEF, resp OKAY → rsp_rdata 0xDEADBEEF, err 0.
- Write answered with B=SLVERR (2'b10), repeated 300 times → rsp_err 1 each time, err_cnt saturates at 255.
- Assert rst_i during WR_RESP → outputs return to reset values at once, no rsp pulse; next request completes normally.
- Back-to-back write then read with req_valid held → second request accepted in the rsp_valid cycle of the first, order preserved.
